// File: rtl/aes_leak_receiver.sv
// Receive side of the AES leak path: finds SYNC_WORD followed by four key-chunk words and
// rebuilds the 128-bit key. Optional build macro: PARITY_CHECK_EN (even parity on bit 40).
module aes_leak_receiver #(
    parameter logic [127:0] SYNC_WORD = 128'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_9696_6969,
    parameter logic [7:0]   TIMEOUT   = 8'd16,
    parameter int           CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [127:0]     in_data,
    output logic [127:0]     key_out,
    output logic             key_valid,
    output logic             frame_err,
    output logic             busy,
    output logic [CNT_W-1:0] frames_ok
);

    // Handshake: in_valid has no back-pressure; a word is consumed on every rising clk edge
    // where in_valid is high, and ignored otherwise.
    typedef enum logic [1:0] {ST_HUNT, ST_COLLECT, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         gap_q, gap_d;
    logic [127:0]       key_buf_q, key_buf_d;
    logic [127:0]       key_out_q, key_out_d;
    logic               key_valid_q, key_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   frames_ok_q, frames_ok_d;

    logic               is_sync;
    logic               parity_ok;
    logic [7:0]         gap_inc;

    assign is_sync = (in_data == SYNC_WORD);
    assign gap_inc = gap_q + 8'd1;

`ifdef PARITY_CHECK_EN
    assign parity_ok = (in_data[40] == ^in_data[31:0]);
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        key_buf_d   = key_buf_q;
        key_out_d   = key_out_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;
        frames_ok_d = frames_ok_q;

        case (state_q)
            ST_COLLECT: begin
                if (in_valid) begin
                    if (is_sync) begin
                        idx_d       = 2'd0;
                        gap_d       = 8'd0;
                        frame_err_d = 1'b1;
                    end else if (in_data[33:32] != idx_q || !parity_ok) begin
                        idx_d       = 2'd0;
                        gap_d       = 8'd0;
                        frame_err_d = 1'b1;
                        state_d     = ST_HUNT;
                    end else begin
                        key_buf_d[32*idx_q +: 32] = in_data[31:0];
                        idx_d = idx_q + 2'd1;
                        gap_d = 8'd0;
                        if (idx_q == 2'd3) begin
                            state_d = ST_DONE;
                        end
                    end
                end else if (TIMEOUT != 8'd0) begin
                    // Counter stops at TIMEOUT because the frame is abandoned on reaching it.
                    gap_d = gap_inc;
                    if (gap_inc == TIMEOUT) begin
                        idx_d       = 2'd0;
                        gap_d       = 8'd0;
                        frame_err_d = 1'b1;
                        state_d     = ST_HUNT;
                    end
                end
            end
            default: begin
                if (state_q == ST_DONE) begin
                    key_out_d   = key_buf_q;
                    key_valid_d = 1'b1;
                    if (frames_ok_q != {CNT_W{1'b1}}) begin
                        frames_ok_d = frames_ok_q + CNT_W'(1);
                    end
                    state_d = ST_HUNT;
                end
                // The DONE cycle also hunts, so a SYNC here opens the next frame directly.
                if (in_valid && is_sync) begin
                    state_d = ST_COLLECT;
                    idx_d   = 2'd0;
                    gap_d   = 8'd0;
                end
            end
        endcase

        busy_d = (state_d == ST_COLLECT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            idx_q       <= 2'd0;
            gap_q       <= 8'd0;
            key_buf_q   <= '0;
            key_out_q   <= '0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            frames_ok_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            key_buf_q   <= key_buf_d;
            key_out_q   <= key_out_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
            frames_ok_q <= frames_ok_d;
        end
    end

    assign key_out   = key_out_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;
    assign frames_ok = frames_ok_q;

endmodule

// File: tb/tb_aes_leak_receiver.sv
// Self-checking bench for aes_leak_receiver: directed scenarios plus random frame traffic,
// compared every cycle against a frame-level reference model.
module tb_aes_leak_receiver;

    localparam logic [127:0] SYNC      = 128'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_9696_6969;
    localparam int           TMO       = 16;
    localparam int           TB_CNT_W  = 4;   // narrow counter so saturation is reachable
    localparam int           FR_MAX    = (1 << TB_CNT_W) - 1;
    localparam int           OBS_W     = 128 + 3 + TB_CNT_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [127:0]        in_data;
    logic [127:0]        key_out;
    logic                key_valid;
    logic                frame_err;
    logic                busy;
    logic [TB_CNT_W-1:0] frames_ok;

    int checks   = 0;
    int failures = 0;

    aes_leak_receiver #(
        .SYNC_WORD (SYNC),
        .TIMEOUT   (8'(TMO)),
        .CNT_W     (TB_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .key_out   (key_out),
        .key_valid (key_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .frames_ok (frames_ok)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    logic [OBS_W-1:0] obs;
    assign obs = {key_out, key_valid, frame_err, busy, frames_ok};

    // ---------------- reference model ----------------
    // m_next < 0: not inside a frame; otherwise the chunk index expected next.
    int           m_next;
    int           m_gap;
    bit           m_done_pending;
    logic [31:0]  m_chunks[4];
    logic [127:0] m_key;
    bit           m_kv, m_err, m_busy;
    int           m_frames;

    function automatic bit parity_good(input logic [127:0] d);
`ifdef PARITY_CHECK_EN
        return d[40] == ^d[31:0];
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_reset();
        m_next = -1; m_gap = 0; m_done_pending = 0;
        for (int i = 0; i < 4; i++) m_chunks[i] = '0;
        m_key = '0; m_kv = 0; m_err = 0; m_busy = 0; m_frames = 0;
    endfunction

    function automatic void model_step(input bit v, input logic [127:0] d);
        m_kv  = m_done_pending;
        m_err = 0;
        if (m_done_pending) begin
            m_key = {m_chunks[3], m_chunks[2], m_chunks[1], m_chunks[0]};
            if (m_frames < FR_MAX) m_frames++;
        end
        m_done_pending = 0;
        if (m_next < 0) begin
            if (v && d == SYNC) begin m_next = 0; m_gap = 0; end
        end else if (v) begin
            if (d == SYNC) begin
                m_next = 0; m_gap = 0; m_err = 1;
            end else if (int'(d[33:32]) != m_next || !parity_good(d)) begin
                m_next = -1; m_err = 1;
            end else begin
                m_chunks[m_next] = d[31:0];
                m_gap = 0;
                if (m_next == 3) begin m_next = -1; m_done_pending = 1; end
                else m_next++;
            end
        end else begin
            m_gap++;
            if (TMO != 0 && m_gap >= TMO) begin m_next = -1; m_err = 1; end
        end
        m_busy = (m_next >= 0);
    endfunction

    function automatic logic [OBS_W-1:0] exp_vec();
        return {m_key, m_kv, m_err, m_busy, TB_CNT_W'(m_frames)};
    endfunction

    // ---------------- driver ----------------
    logic [128:0] stim_q[$];

    task automatic apply(input bit v, input logic [127:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        model_step(v, d);
        #1;
    endtask

    function automatic logic [127:0] mk_chunk(input int idx, input logic [31:0] val, input bit flip);
        logic [127:0] w;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[31:0]  = val;
        w[33:32] = idx[1:0];
        w[40]    = (^val) ^ flip;
        return w;
    endfunction

    function automatic void push_idle(input int n);
        for (int i = 0; i < n; i++) stim_q.push_back({1'b0, 128'($urandom)});
    endfunction

    function automatic void push_word(input logic [127:0] w);
        stim_q.push_back({1'b1, w});
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (obs !== '0) begin
            failures++; $display("FAIL reset_values got=%h want=0", obs);
        end
        rst = 1'b0;
        model_reset();
        apply(0, '0);
        checks++;
        if (obs !== exp_vec()) begin
            failures++; $display("FAIL reset_release got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_good_frame();
        logic [127:0] want;
        want = 128'h44444444_33333333_22222222_11111111;
        apply(1, SYNC);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL gf_busy got=%b want=1", busy); end
        for (int i = 0; i < 4; i++) begin
            apply(1, mk_chunk(i, 32'(32'h1111_1111 * (i + 1)), 1'b0));
            checks++;
            if (obs !== exp_vec()) begin
                failures++; $display("FAIL gf_chunk%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        checks++;
        if (key_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL gf_done_cycle got=kv%b busy%b want=kv0 busy0", key_valid, busy);
        end
        apply(0, '0);
        checks++;
        if (key_valid !== 1'b1 || key_out !== want || frame_err !== 1'b0) begin
            failures++; $display("FAIL gf_key got=%b/%h want=1/%h", key_valid, key_out, want);
        end
        apply(0, '0);
        checks++;
        if (key_valid !== 1'b0 || frames_ok !== TB_CNT_W'(1) || key_out !== want) begin
            failures++; $display("FAIL gf_after got=kv%b cnt%0d want=kv0 cnt1", key_valid, frames_ok);
        end
    endtask

    task automatic test_out_of_order();
        int kv_cnt;
        logic [127:0] prev_key;
        prev_key = m_key;
        apply(1, SYNC);
        apply(1, mk_chunk(0, 32'hDEAD_0000, 1'b0));
        apply(1, mk_chunk(2, 32'hDEAD_0002, 1'b0));
        checks++;
        if (frame_err !== 1'b1 || busy !== 1'b0 || key_out !== prev_key) begin
            failures++; $display("FAIL ooo_err got=err%b busy%b key%h want=err1 busy0 key%h",
                                 frame_err, busy, key_out, prev_key);
        end
        push_idle(2);
        push_word(SYNC);
        for (int i = 0; i < 4; i++) push_word(mk_chunk(i, $urandom, 1'b0));
        push_idle(3);
        kv_cnt = 0;
        while (stim_q.size() > 0) begin
            logic [128:0] w;
            w = stim_q.pop_front();
            apply(w[128], w[127:0]);
            checks++;
            if (obs !== exp_vec()) begin
                failures++; $display("FAIL ooo_follow got=%h want=%h", obs, exp_vec());
            end
            if (key_valid) kv_cnt++;
        end
        checks++;
        if (kv_cnt != 1) begin failures++; $display("FAIL ooo_accept got=%0d want=1", kv_cnt); end
    endtask

    task automatic test_timeout();
        int kv_cnt;
        apply(1, SYNC);
        apply(1, mk_chunk(0, $urandom, 1'b0));
        for (int i = 1; i <= TMO; i++) begin
            apply(0, '0);
            checks++;
            if (frame_err !== (i == TMO) || busy !== (i != TMO)) begin
                failures++; $display("FAIL tmo_idle%0d got=err%b busy%b want=err%b busy%b",
                                     i, frame_err, busy, i == TMO, i != TMO);
            end
        end
        apply(1, SYNC);
        apply(1, mk_chunk(0, 32'hCAFE_0000, 1'b0));
        for (int i = 0; i < TMO - 1; i++) apply(0, '0);
        kv_cnt = 0;
        for (int i = 1; i < 4; i++) begin
            apply(1, mk_chunk(i, 32'(32'hCAFE_0000 + i), 1'b0));
            if (frame_err) kv_cnt = -100;
        end
        apply(0, '0);
        apply(0, '0);
        checks++;
        if (kv_cnt != 0 || key_out !== 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000 || obs !== exp_vec()) begin
            failures++; $display("FAIL tmo_gap15 got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_resync();
        int kv_cnt, err_cnt;
        logic [127:0] want;
        push_word(SYNC);
        push_word(mk_chunk(0, 32'h0BAD_0BAD, 1'b0));
        push_word(SYNC);
        for (int i = 0; i < 4; i++) push_word(mk_chunk(i, 32'(32'h5EC0_0000 + i), 1'b0));
        push_idle(3);
        want = 128'h5EC00003_5EC00002_5EC00001_5EC00000;
        kv_cnt = 0; err_cnt = 0;
        while (stim_q.size() > 0) begin
            logic [128:0] w;
            w = stim_q.pop_front();
            apply(w[128], w[127:0]);
            checks++;
            if (obs !== exp_vec()) begin
                failures++; $display("FAIL resync_cycle got=%h want=%h", obs, exp_vec());
            end
            if (key_valid) kv_cnt++;
            if (frame_err) err_cnt++;
            if (key_valid && frame_err) err_cnt += 100;
        end
        checks++;
        if (kv_cnt != 1 || err_cnt != 1 || key_out !== want) begin
            failures++; $display("FAIL resync_result got=kv%0d err%0d key%h want=kv1 err1 key%h",
                                 kv_cnt, err_cnt, key_out, want);
        end
    endtask

    task automatic test_parity();
        int kv_cnt, err_cnt, cnt_before;
        cnt_before = int'(frames_ok);
        push_word(SYNC);
        for (int i = 0; i < 4; i++) push_word(mk_chunk(i, $urandom, i == 2));
        push_idle(3);
        kv_cnt = 0; err_cnt = 0;
        while (stim_q.size() > 0) begin
            logic [128:0] w;
            w = stim_q.pop_front();
            apply(w[128], w[127:0]);
            checks++;
            if (obs !== exp_vec()) begin
                failures++; $display("FAIL parity_cycle got=%h want=%h", obs, exp_vec());
            end
            if (key_valid) kv_cnt++;
            if (frame_err) err_cnt++;
        end
        checks++;
`ifdef PARITY_CHECK_EN
        if (err_cnt != 1 || kv_cnt != 0 || int'(frames_ok) != cnt_before) begin
            failures++; $display("FAIL parity_reject got=err%0d kv%0d cnt%0d want=err1 kv0 cnt%0d",
                                 err_cnt, kv_cnt, frames_ok, cnt_before);
        end
`else
        if (err_cnt != 0 || kv_cnt != 1 || int'(frames_ok) != cnt_before + 1) begin
            failures++; $display("FAIL parity_ignored got=err%0d kv%0d cnt%0d want=err0 kv1 cnt%0d",
                                 err_cnt, kv_cnt, frames_ok, cnt_before + 1);
        end
`endif
    endtask

    task automatic test_random();
        for (int f = 0; f < 40; f++) begin
            push_idle($urandom_range(0, 2));
            push_word(SYNC);
            for (int i = 0; i < 4; i++) begin
                int r;
                push_idle(($urandom_range(0, 9) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 2));
                r = $urandom_range(0, 24);
                if (r == 0) push_word(SYNC);
                push_word(mk_chunk((r == 1) ? (i ^ 1) : i, $urandom, r == 2));
            end
        end
        push_idle(4);
        while (stim_q.size() > 0) begin
            logic [128:0] w;
            w = stim_q.pop_front();
            apply(w[128], w[127:0]);
            checks++;
            if (obs !== exp_vec()) begin
                failures++; $display("FAIL random_cycle got=%h want=%h", obs, exp_vec());
            end
        end
        checks++;
        if (m_frames > 0 && frames_ok === '0) begin
            failures++; $display("FAIL random_count got=%0d want=%0d", frames_ok, m_frames);
        end
    endtask

    task automatic test_reset_mid();
        apply(1, SYNC);
        apply(1, mk_chunk(0, $urandom, 1'b0));
        apply(1, mk_chunk(1, $urandom, 1'b0));
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=busy%b want=1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== '0) begin failures++; $display("FAIL rstmid_async got=%h want=0", obs); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        push_word(mk_chunk(2, $urandom, 1'b0));
        push_word(mk_chunk(3, $urandom, 1'b0));
        push_idle(3);
        while (stim_q.size() > 0) begin
            logic [128:0] w;
            w = stim_q.pop_front();
            apply(w[128], w[127:0]);
            checks++;
            if (obs !== exp_vec() || key_valid !== 1'b0) begin
                failures++; $display("FAIL rstmid_after got=%h want=%h", obs, exp_vec());
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_good_frame();
        test_out_of_order();
        test_timeout();
        test_resync();
        test_parity();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
